// File: rtl/compute_seq_pkg.sv
// compute_seq_pkg: shared types and constants for the batch sequencer.
// Holds the FSM state enum, slave register addresses and size defaults.
package compute_seq_pkg;

    localparam int N_VALUES_DEF = 8;
    localparam int ADDR_W_DEF   = 4;

    localparam logic [3:0] ADDR_SUM = 4'd8;
    localparam logic [3:0] ADDR_PAR = 4'd9;

    typedef enum logic [2:0] {
        FILL    = 3'd0,
        RD_SUM  = 3'd1,
        RD_PAR  = 3'd2,
        CAP_PAR = 3'd3,
        CAP_SUM = 3'd4,
        RESULT  = 3'd5
    } state_t;

endpackage

// File: rtl/compute_seq.sv
// compute_seq: writes each batch of N_VALUES samples into the summing slave,
// reads back sum (addr 8) and even flag (addr 9), presents one result beat.
// Ports: iClk/iReset_n (async low); iValid/iSample/oReady sample input;
// oResValid/oSum/oEven/iResReady result output; oChipSelect_n, oWrite_n,
// oRead_n, oAddress, oData, iData slave bus (strobes registered, active-low).
// Macro COMPUTE_SEQ_PARITY_EN: when defined the parity register is read back;
// otherwise the sum is captured straight after RD_SUM and oEven is tied 0.
module compute_seq
    import compute_seq_pkg::*;
#(
    parameter int N_VALUES = N_VALUES_DEF,
    parameter int ADDR_W   = ADDR_W_DEF
) (
    input  logic              iClk,
    input  logic              iReset_n,
    input  logic              iValid,
    input  logic [31:0]       iSample,
    output logic              oReady,
    output logic              oResValid,
    output logic [31:0]       oSum,
    output logic              oEven,
    input  logic              iResReady,
    output logic              oChipSelect_n,
    output logic              oWrite_n,
    output logic              oRead_n,
    output logic [ADDR_W-1:0] oAddress,
    output logic [31:0]       oData,
    input  logic [31:0]       iData
);

    localparam int IDX_W = $clog2(N_VALUES);

    state_t             state, nState;
    logic               lastWr, nLastWr;
    logic [IDX_W-1:0]   idx, nIdx;
    logic               csN, nCsN;
    logic               wrN, nWrN;
    logic               rdN, nRdN;
    logic [ADDR_W-1:0]  addr, nAddr;
    logic [31:0]        data, nData;
    logic [31:0]        sumQ, nSum;
    logic               accept;

    // lastWr marks the cycle in which the final write of a batch is on
    // the bus; no new sample may be taken while it drains.
    assign oReady = (state == FILL) && !lastWr;
    assign accept = iValid && oReady;

    assign oResValid     = (state == RESULT);
    assign oSum          = sumQ;
    assign oChipSelect_n = csN;
    assign oWrite_n      = wrN;
    assign oRead_n       = rdN;
    assign oAddress      = addr;
    assign oData         = data;

`ifdef COMPUTE_SEQ_PARITY_EN
    logic evenQ, nEven;
    assign oEven = evenQ;
`else
    assign oEven = 1'b0;
`endif

    always_comb begin
        nState  = state;
        nLastWr = lastWr;
        nIdx    = idx;
        nCsN    = 1'b1;
        nWrN    = 1'b1;
        nRdN    = 1'b1;
        nAddr   = addr;
        nData   = data;
        nSum    = sumQ;
`ifdef COMPUTE_SEQ_PARITY_EN
        nEven   = evenQ;
`endif
        unique case (state)
            FILL: begin
                if (lastWr) begin
                    nLastWr = 1'b0;
                    nState  = RD_SUM;
                end else if (accept) begin
                    nCsN  = 1'b0;
                    nWrN  = 1'b0;
                    nAddr = ADDR_W'(idx);
                    nData = iSample;
                    if (idx == IDX_W'(N_VALUES - 1)) begin
                        nIdx    = '0;
                        nLastWr = 1'b1;
                    end else begin
                        nIdx = idx + 1'b1;
                    end
                end
            end
`ifdef COMPUTE_SEQ_PARITY_EN
            RD_SUM: nState = RD_PAR;
            // Slave returns the addr-8 data one cycle after the strobe.
            RD_PAR: begin
                nSum   = iData;
                nState = CAP_PAR;
            end
            CAP_PAR: begin
                nEven  = iData[0];
                nState = RESULT;
            end
`else
            RD_SUM: nState = CAP_SUM;
            CAP_SUM: begin
                nSum   = iData;
                nState = RESULT;
            end
`endif
            RESULT: begin
                if (iResReady) begin
                    nState = FILL;
                end
            end
            default: nState = FILL;
        endcase

        // Read strobes are registered off the next state so the bus
        // phase lines up with the state that owns it.
        unique case (nState)
            RD_SUM: begin
                nCsN  = 1'b0;
                nRdN  = 1'b0;
                nAddr = ADDR_W'(ADDR_SUM);
            end
`ifdef COMPUTE_SEQ_PARITY_EN
            RD_PAR: begin
                nCsN  = 1'b0;
                nRdN  = 1'b0;
                nAddr = ADDR_W'(ADDR_PAR);
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            state  <= FILL;
            lastWr <= 1'b0;
            idx    <= '0;
            csN    <= 1'b1;
            wrN    <= 1'b1;
            rdN    <= 1'b1;
            addr   <= '0;
            data   <= '0;
            sumQ   <= '0;
        end else begin
            state  <= nState;
            lastWr <= nLastWr;
            idx    <= nIdx;
            csN    <= nCsN;
            wrN    <= nWrN;
            rdN    <= nRdN;
            addr   <= nAddr;
            data   <= nData;
            sumQ   <= nSum;
        end
    end

`ifdef COMPUTE_SEQ_PARITY_EN
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            evenQ <= 1'b0;
        end else begin
            evenQ <= nEven;
        end
    end
`endif

endmodule

// File: tb/tb_compute_seq.sv
// tb_compute_seq: directed bench for compute_seq with a summing-slave model.
// Covers reset, back-to-back, backpressure, overflow and gapped input.
module tb_compute_seq;

`ifdef COMPUTE_SEQ_PARITY_EN
    localparam int LAT = 5;
    localparam int PAR = 1;
`else
    localparam int LAT = 4;
    localparam int PAR = 0;
`endif

    logic        iClk = 1'b0;
    logic        iReset_n = 1'b0;
    logic        iValid = 1'b0;
    logic [31:0] iSample = '0;
    logic        oReady;
    logic        oResValid;
    logic [31:0] oSum;
    logic        oEven;
    logic        iResReady = 1'b0;
    logic        oChipSelect_n;
    logic        oWrite_n;
    logic        oRead_n;
    logic [3:0]  oAddress;
    logic [31:0] oData;
    logic [31:0] iData;

    always #5 iClk = ~iClk;

    compute_seq dut (
        .iClk(iClk), .iReset_n(iReset_n),
        .iValid(iValid), .iSample(iSample), .oReady(oReady),
        .oResValid(oResValid), .oSum(oSum), .oEven(oEven),
        .iResReady(iResReady),
        .oChipSelect_n(oChipSelect_n), .oWrite_n(oWrite_n),
        .oRead_n(oRead_n), .oAddress(oAddress), .oData(oData),
        .iData(iData)
    );

    // Summing slave: 8 value regs, sum refreshed on addr-8 read.
    logic [31:0] regs [8];
    logic [31:0] slvSum;

    function automatic logic [31:0] regSum();
        logic [31:0] s = '0;
        for (int i = 0; i < 8; i++) s = s + regs[i];
        return s;
    endfunction

    always @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            for (int i = 0; i < 8; i++) regs[i] <= '0;
            slvSum <= '0;
            iData  <= '0;
        end else if (!oChipSelect_n) begin
            if (!oWrite_n && oAddress < 4'd8) regs[oAddress[2:0]] <= oData;
            if (!oRead_n) begin
                if (oAddress == 4'd8) begin
                    slvSum <= regSum();
                    iData  <= regSum();
                end else if (oAddress == 4'd9) begin
                    iData <= {31'b0, ~slvSum[0]};
                end else begin
                    iData <= regs[oAddress[2:0]];
                end
            end
        end
    end

    // Bus monitor
    int cyc = 0;
    always @(posedge iClk) cyc <= cyc + 1;

    logic [3:0]  wrAddrQ [$];
    logic [31:0] wrDataQ [$];
    int          wrCycQ [$];
    int          rd8Cnt, rd9Cnt, clash;

    always @(negedge iClk) begin
        if (iReset_n) begin
            if (!oChipSelect_n && !oWrite_n) begin
                wrAddrQ.push_back(oAddress);
                wrDataQ.push_back(oData);
                wrCycQ.push_back(cyc);
            end
            if (!oChipSelect_n && !oRead_n && oAddress == 4'd8) rd8Cnt++;
            if (!oChipSelect_n && !oRead_n && oAddress == 4'd9) rd9Cnt++;
            if (!oWrite_n && !oRead_n) clash++;
            if (oChipSelect_n && (!oWrite_n || !oRead_n)) clash++;
        end
    end

    int nCmp = 0;
    int nBad = 0;
    int accCyc, resCyc;
    logic [31:0] smp [8];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nCmp++;
        assert (got === exp) else begin
            nBad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clearMon();
        wrAddrQ.delete();
        wrDataQ.delete();
        wrCycQ.delete();
        rd8Cnt = 0;
        rd9Cnt = 0;
        clash  = 0;
    endtask

    task automatic putSample(input logic [31:0] v, input int gap);
        int n;
        for (int g = 0; g < gap; g++) @(negedge iClk);
        @(negedge iClk);
        iValid  = 1'b1;
        iSample = v;
        n = 0;
        while (!oReady && n < 50) begin
            @(negedge iClk);
            n++;
        end
        chk("ready_wait", oReady, 1);
        @(posedge iClk);
        #1;
        accCyc = cyc - 1;
        iValid = 1'b0;
    endtask

    task automatic sendBatch(input int gap);
        for (int i = 0; i < 8; i++) putSample(smp[i], gap);
    endtask

    task automatic waitResult();
        int n = 0;
        @(negedge iClk);
        while (!oResValid && n < 40) begin
            @(negedge iClk);
            n++;
        end
        resCyc = cyc;
        chk("res_valid", oResValid, 1);
    endtask

    task automatic checkWrites(input string tag);
        chk({tag, "_wrcnt"}, wrAddrQ.size(), 8);
        for (int i = 0; i < 8; i++) begin
            chk({tag, "_wraddr"}, {28'b0, wrAddrQ[i]}, i);
            chk({tag, "_wrdata"}, wrDataQ[i], smp[i]);
        end
        chk({tag, "_clash"}, clash, 0);
        chk({tag, "_rd8"}, rd8Cnt, 1);
        chk({tag, "_rd9"}, rd9Cnt, PAR);
    endtask

    task automatic handshake();
        @(negedge iClk);
        iResReady = 1'b1;
        @(posedge iClk);
        #1;
        iResReady = 1'b0;
        @(negedge iClk);
        chk("hs_resvalid", oResValid, 0);
        chk("hs_ready", oReady, 1);
    endtask

    task automatic checkReset();
        chk("rst_ready", oReady, 1);
        chk("rst_resvalid", oResValid, 0);
        chk("rst_sum", oSum, 0);
        chk("rst_even", oEven, 0);
        chk("rst_cs", oChipSelect_n, 1);
        chk("rst_wr", oWrite_n, 1);
        chk("rst_rd", oRead_n, 1);
        chk("rst_addr", {28'b0, oAddress}, 0);
        chk("rst_data", oData, 0);
    endtask

    initial begin
        // Power-on reset
        #12;
        checkReset();
        @(negedge iClk);
        iReset_n = 1'b1;

        // Back-to-back 1..8: sum 36, even
        clearMon();
        for (int i = 0; i < 8; i++) smp[i] = 32'(i + 1);
        sendBatch(0);
        waitResult();
        chk("b2b_lat", resCyc - accCyc, LAT);
        chk("b2b_sum", oSum, 32'd36);
        chk("b2b_even", oEven, PAR);
        checkWrites("b2b");
        chk("b2b_wrspan", wrCycQ[7] - wrCycQ[0], 7);
        chk("b2b_wr7lat", wrCycQ[7] - accCyc, 1);
        handshake();

        // Odd sum, consumer stalls 4 cycles, iValid ignored meanwhile
        clearMon();
        smp = '{32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd2};
        sendBatch(0);
        waitResult();
        iValid  = 1'b1;
        iSample = 32'd99;
        for (int k = 0; k < 4; k++) begin
            chk("bp_sum", oSum, 32'd3);
            chk("bp_even", oEven, 0);
            chk("bp_resvalid", oResValid, 1);
            chk("bp_ready", oReady, 0);
            @(negedge iClk);
        end
        iValid = 1'b0;
        checkWrites("bp");
        handshake();

        // Overflow: 8 x 0xFFFFFFFF = 0xFFFFFFF8
        clearMon();
        for (int i = 0; i < 8; i++) smp[i] = 32'hFFFF_FFFF;
        sendBatch(0);
        waitResult();
        chk("ovf_sum", oSum, 32'hFFFF_FFF8);
        chk("ovf_even", oEven, PAR);
        checkWrites("ovf");
        handshake();

        // Gapped input 10..17: sum 108
        clearMon();
        for (int i = 0; i < 8; i++) smp[i] = 32'(i + 10);
        sendBatch(1);
        waitResult();
        chk("gap_sum", oSum, 32'd108);
        chk("gap_even", oEven, PAR);
        checkWrites("gap");
        handshake();

        // Reset mid-batch, then a fresh batch starts at address 0
        for (int i = 0; i < 3; i++) putSample(32'd7, 0);
        @(negedge iClk);
        iReset_n = 1'b0;
        #1;
        checkReset();
        @(negedge iClk);
        iReset_n = 1'b1;
        clearMon();
        smp = '{32'd3, 32'd3, 32'd3, 32'd3, 32'd3, 32'd3, 32'd3, 32'd4};
        sendBatch(0);
        waitResult();
        chk("rst2_sum", oSum, 32'd25);
        chk("rst2_even", oEven, 0);
        checkWrites("rst2");
        handshake();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule

// File: doc/compute_seq.md
# compute_seq

Bus-master sequencer that sits directly upstream of the 8-entry summing slave. It accepts a stream of 32-bit samples over a valid/ready handshake and writes each batch of 8 into slave addresses 0..7. It then reads the slave's sum (address 8) and even-parity flag (address 9) and presents them as one result beat to the consumer. All slave-side strobes are active-low and registered.

## Interface
- N_VALUES, 8: samples per batch; equals the slave's value-register count.
- ADDR_W, 4: slave address width.
- iClk  in  1  clock; all logic is on the rising edge.
- iReset_n  in  1  reset, asynchronous, active-low.
- iValid  in  1  upstream sample valid.
- iSample  in  32  upstream sample.
- oReady  out  1  sequencer accepts a sample this cycle.
- oResValid  out  1  result beat valid.
- oSum  out  32  batch sum, mod 2^32.
- oEven  out  1  1 when the sum is even, 0 when odd.
- iResReady  in  1  consumer accepts the result.
- oChipSelect_n  out  1  slave select, active-low.
- oWrite_n  out  1  slave write strobe, active-low.
- oRead_n  out  1  slave read strobe, active-low.
- oAddress  out  ADDR_W  slave address.
- oData  out  32  slave write data.
- iData  in  32  slave read data; registered by the slave one cycle after the read strobe.

## Operation
- States: FILL, RD_SUM, RD_PAR, CAP_PAR, RESULT.
- FILL
  - oReady=1.
  - Each accept (iValid&&oReady) latches iSample and a 3-bit index idx.
  - Next cycle: CS_n=0, Write_n=0, Address=idx, Data=sample; idx then increments.
  - Back-to-back accepts produce one write per cycle.
  - On the accept with idx=N_VALUES-1, idx wraps to 0 and the FSM goes to RD_SUM after that final write is issued.
- RD_SUM: CS_n=0, Read_n=0, Address=8 for one cycle.
- RD_PAR
  - Read strobe to Address=9 for one cycle.
  - Same cycle: iData is captured into the sum register.
- CAP_PAR: capture iData[0] into the parity register.
- RESULT
  - oResValid=1; oSum and oEven are held stable.
  - oReady=0.
  - On iResReady, go to FILL with oResValid=0 the next cycle.
- Address 9 must be read only after address 8: the slave refreshes its internal sum on the address-8 read.
- Read and write strobes are never asserted in the same cycle. All strobes deassert (=1) when idle.
- Sum overflow wraps mod 2^32; this is the slave's arithmetic and is passed through unchanged.
- Reset mid-batch or mid-result:
  - FSM returns to FILL, idx=0, and partially written values are discarded.
  - The slave shares iReset_n and clears with it.
- iValid while oReady=0 (RESULT, read states) is ignored. Upstream must hold the sample.

## Timing
- Reset values:
  - oReady=1 (FILL).
  - oResValid=0, oSum=0, oEven=0.
  - oChipSelect_n=1, oWrite_n=1, oRead_n=1.
  - oAddress=0, oData=0.
- Write latency: a sample accepted in cycle t produces a write strobe in t+1.
- Last sample accepted in cycle t:
  - t+1: write to address 7.
  - t+2: RD_SUM strobe.
  - t+3: RD_PAR strobe, sum captured at the end of the cycle.
  - t+4: parity captured.
  - t+5: oResValid=1.
- Minimum batch period is 8 accepts plus 5 cycles, including a one-cycle result handshake.
- oReady drops in the cycle after the 8th accept.

## Configuration
- COMPUTE_SEQ_PARITY_EN
  - Defined: behaviour exactly as above.
  - Undefined:
    - RD_PAR and CAP_PAR are removed.
    - RD_SUM is followed by a CAP_SUM cycle that captures iData into the sum register.
    - oResValid rises at t+4.
    - Address 9 is never accessed.
    - oEven is tied to 0.

## Structure
- Package compute_seq_pkg holds:
  - the state enum;
  - ADDR_SUM=4'd8 and ADDR_PAR=4'd9;
  - the N_VALUES default.
- Single module; no sub-module. The FSM, index counter and result registers are small enough to live together.

## Test plan
- Reset check: assert reset mid-stream, then release → every output at its reset value, oReady=1, next batch written starting at address 0.
- Back-to-back batch: samples 1..8 with continuous iValid → writes to addresses 0..7 on consecutive cycles, then read 8, read 9, oSum=36, oEven=1, oResValid at t+5.
- Odd sum with backpressure: samples 1,0,0,0,0,0,0,2, iResReady low for 4 cycles → oSum=3 and oEven=0 held stable, oReady=0 throughout, then FILL resumes.
- Overflow: samples 0xFFFFFFFF ×8 → oSum=0xFFFFFFF8, oEven=1.
- Gapped input: iValid toggling every other cycle → exactly one write per accept, no spurious strobes, correct sum.
- Macro undefined: samples 1..8 → no address-9 access, oSum=36, oEven=0, oResValid at t+4.
